// File: rtl/vga_pkg.sv
// Shared VGA constants and the button-decode helper used by every paddle channel.
package vga_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned V_VISIBLE = 480;

    localparam logic [2:0] C_RED   = 3'b100;
    localparam logic [2:0] C_GREEN = 3'b010;
    localparam logic [2:0] C_BLUE  = 3'b001;
    localparam logic [2:0] C_BLACK = 3'b000;

    typedef enum logic [1:0] {
        MV_HOLD = 2'd0,
        MV_UP   = 2'd1,
        MV_DOWN = 2'd2
    } move_t;

    // Pressing both buttons cancels out, the same as pressing neither.
    function automatic move_t decode_move(input logic up, input logic down);
        if (down && !up)
            return MV_DOWN;
        if (up && !down)
            return MV_UP;
        return MV_HOLD;
    endfunction

endpackage

// File: rtl/paddle_channel.sv
// One paddle: button synchroniser, clamped vertical position and pixel hit test.
module paddle_channel
    import vga_pkg::*;
#(
    parameter int unsigned STEP     = 2,
    parameter int unsigned HALF_H   = 10,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned Y_MIN    = 0,
    parameter int unsigned Y_MAX    = 479,
    parameter int unsigned INIT_POS = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        freeze,
    input  logic        up,
    input  logic        down,
    input  logic [9:0]  CounterX,
    input  logic [9:0]  CounterY,
    input  logic [10:0] x_left,
    output logic [9:0]  pos,
    output logic        hit
);

    localparam logic [10:0] LO     = 11'(Y_MIN + HALF_H);
    localparam logic [10:0] HI     = 11'(Y_MAX - HALF_H);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] HALF_W = 11'(HALF_H);
    localparam logic [10:0] WID_W  = 11'(WIDTH);

    logic [1:0]  up_sync;
    logic [1:0]  down_sync;
    logic [10:0] pos_w;
    logic [10:0] cand;
    logic [10:0] next_pos;
    logic [10:0] cx;
    logic [10:0] cy;
    move_t       move;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_sync   <= '0;
            down_sync <= '0;
        end else begin
            up_sync   <= {up_sync[0], up};
            down_sync <= {down_sync[0], down};
        end
    end

    // Any move request clamps into range, which also pulls an out-of-range INIT_POS to the nearer bound.
    always_comb begin
        pos_w = {1'b0, pos};
        move  = decode_move(up_sync[1], down_sync[1]);
        cand  = pos_w;
        case (move)
            MV_DOWN: cand = pos_w + STEP_W;
            MV_UP:   cand = (pos_w >= STEP_W) ? pos_w - STEP_W : '0;
            default: cand = pos_w;
        endcase
        if (move == MV_HOLD)
            next_pos = pos_w;
        else if (cand < LO)
            next_pos = LO;
        else if (cand > HI)
            next_pos = HI;
        else
            next_pos = cand;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pos <= 10'(INIT_POS);
        else if (tick && !freeze)
            pos <= next_pos[9:0];
    end

    // Vertical test is rearranged as cy+HALF_H >= pos so that nothing goes negative near the top edge.
    always_comb begin
        cx  = {1'b0, CounterX};
        cy  = {1'b0, CounterY};
        hit = (cx >= x_left) && (cx < x_left + WID_W)
              && (cy + HALF_W >= pos_w) && (cy <= pos_w + HALF_W);
    end

endmodule

// File: rtl/vga_paddle_engine.sv
// N-channel paddle renderer: tick counter, per-channel paddles, priority colour mux, output register.
module vga_paddle_engine
    import vga_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned TICK_LOG2 = 19,
    parameter int unsigned STEP      = 2,
    parameter int unsigned HALF_H    = 10,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned X0        = 224,
    parameter int unsigned X_PITCH   = 160,
    parameter int unsigned Y_MIN     = 0,
    parameter int unsigned Y_MAX     = 479,
    parameter int unsigned INIT_POS  = 240,
    parameter logic [11:0] COLOURS   = 12'o4214
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CH-1:0]      btn_up,
    input  logic [N_CH-1:0]      btn_down,
    input  logic                 freeze,
    input  logic [9:0]           CounterX,
    input  logic [9:0]           CounterY,
    input  logic                 inDisplayArea,
    output logic                 vga_r,
    output logic                 vga_g,
    output logic                 vga_b,
    output logic [10*N_CH-1:0]   pos_out,
    output logic                 tick
);

    logic [TICK_LOG2-1:0] tick_cnt;
    logic [N_CH-1:0]      hits;
    logic [2:0]           colour;
    logic                 found;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    assign tick = &tick_cnt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        paddle_channel #(
            .STEP     (STEP),
            .HALF_H   (HALF_H),
            .WIDTH    (WIDTH),
            .Y_MIN    (Y_MIN),
            .Y_MAX    (Y_MAX),
            .INIT_POS (INIT_POS)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .freeze   (freeze),
            .up       (btn_up[i]),
            .down     (btn_down[i]),
            .CounterX (CounterX),
            .CounterY (CounterY),
            .x_left   (11'(X0 + i * X_PITCH)),
            .pos      (pos_out[10*i +: 10]),
            .hit      (hits[i])
        );
    end

    // Lowest-index channel wins where paddles overlap.
    always_comb begin
        colour = C_BLACK;
        found  = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (hits[i] && !found) begin
                colour = COLOURS[3*i +: 3];
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            {vga_r, vga_g, vga_b} <= '0;
        else
            {vga_r, vga_g, vga_b} <= colour & {3{inDisplayArea}};
    end

endmodule

// File: tb/tb_vga_paddle_engine.sv
// Directed and randomized bench for vga_paddle_engine against a plain-arithmetic paddle model.
module tb_vga_paddle_engine;

    localparam int NCH   = 2;
    localparam int TL    = 3;
    localparam int PER   = 8;
    localparam int X0V   = 224;
    localparam int PITCH = 160;
    localparam int WV    = 32;
    localparam int HH    = 10;
    localparam int STEPV = 2;
    localparam int LO    = 10;
    localparam int HI    = 469;
    localparam int INIT  = 240;
    localparam logic [11:0] COL = 12'o4214;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  btn_up = '0;
    logic [1:0]  btn_down = '0;
    logic        freeze = 1'b0;
    logic [9:0]  cx = '0;
    logic [9:0]  cy = '0;
    logic        disp = 1'b0;

    logic        r1, g1, b1, tick1;
    logic        r2, g2, b2, tick2;
    logic [19:0] pos1, pos2;

    int checks = 0;
    int errors = 0;

    int mpos[NCH];
    int mcnt;
    logic [1:0] hu[$];
    logic [1:0] hd[$];
    logic [11:0] col_v;

    vga_paddle_engine #(.N_CH(2), .TICK_LOG2(TL)) dut (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .freeze(freeze),
        .CounterX(cx), .CounterY(cy), .inDisplayArea(disp),
        .vga_r(r1), .vga_g(g1), .vga_b(b1), .pos_out(pos1), .tick(tick1)
    );

    vga_paddle_engine #(.N_CH(2), .TICK_LOG2(TL), .X_PITCH(0)) dut_overlap (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .freeze(freeze),
        .CounterX(cx), .CounterY(cy), .inDisplayArea(disp),
        .vga_r(r2), .vga_g(g2), .vga_b(b2), .pos_out(pos2), .tick(tick2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_rgb(input int pitch);
        int x, y, left;
        x = int'(cx);
        y = int'(cy);
        for (int ch = 0; ch < NCH; ch++) begin
            left = X0V + ch * pitch;
            if (x >= left && x < left + WV && y >= mpos[ch] - HH && y <= mpos[ch] + HH)
                return disp ? col_v[3*ch +: 3] : 3'b000;
        end
        return 3'b000;
    endfunction

    function automatic int clamp(input int v);
        if (v < LO) return LO;
        if (v > HI) return HI;
        return v;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) mpos[ch] = INIT;
        mcnt = 0;
        hu = '{2'b00, 2'b00};
        hd = '{2'b00, 2'b00};
    endtask

    function automatic logic [19:0] mpos_vec();
        return {10'(mpos[1]), 10'(mpos[0])};
    endfunction

    // One clock: check tick now, predict the edge, then check outputs just after it.
    task automatic step();
        logic t;
        logic [2:0] e1, e2;
        logic u, d;
        int v;
        t = (mcnt == PER - 1);
        chk("tick", 32'(tick1), 32'(t));
        chk("tick_overlap", 32'(tick2), 32'(t));
        e1 = ref_rgb(PITCH);
        e2 = ref_rgb(0);
        if (t && !freeze) begin
            for (int ch = 0; ch < NCH; ch++) begin
                u = hu[0][ch];
                d = hd[0][ch];
                if (d && !u) mpos[ch] = clamp(mpos[ch] + STEPV);
                else if (u && !d) begin
                    v = mpos[ch] - STEPV;
                    if (v < 0) v = 0;
                    mpos[ch] = clamp(v);
                end
            end
        end
        void'(hu.pop_front());
        void'(hd.pop_front());
        hu.push_back(btn_up);
        hd.push_back(btn_down);
        mcnt = (mcnt + 1) % PER;
        @(posedge clk);
        #1;
        chk("rgb", 32'({r1, g1, b1}), 32'(e1));
        chk("rgb_overlap", 32'({r2, g2, b2}), 32'(e2));
        chk("pos", 32'(pos1), 32'(mpos_vec()));
        chk("pos_overlap", 32'(pos2), 32'(mpos_vec()));
    endtask

    initial begin
        int saved0, saved1, ticks_seen;
        col_v = COL;
        model_reset();

        // T1: reset state, then first tick seven edges after release
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pos", 32'(pos1), 32'({10'd240, 10'd240}));
        chk("reset_rgb", 32'({r1, g1, b1}), 32'(3'b000));
        chk("reset_tick", 32'(tick1), 32'(1'b0));
        reset = 1'b0;
        repeat (PER - 1) step();
        chk("first_tick", 32'(tick1), 32'(1'b1));
        step();

        // T4: render boundaries around channel 0 at row 240
        disp = 1'b1; cx = 10'd224; cy = 10'd230; step();
        chk("render_hit", 32'({r1, g1, b1}), 32'(3'b100));
        cx = 10'd256; step();
        chk("render_right_edge", 32'({r1, g1, b1}), 32'(3'b000));
        cx = 10'd255; cy = 10'd250; step();
        chk("render_bottom_row", 32'({r1, g1, b1}), 32'(3'b100));
        cx = 10'd224; cy = 10'd251; step();
        chk("render_below", 32'({r1, g1, b1}), 32'(3'b000));
        cy = 10'd240; disp = 1'b0; step();
        chk("render_blank", 32'({r1, g1, b1}), 32'(3'b000));

        // T5: overlapping paddles, channel 0 wins
        disp = 1'b1; cx = 10'd230; cy = 10'd240; step();
        chk("overlap_priority", 32'({r2, g2, b2}), 32'(3'b100));

        // T2: clamp at both ends
        btn_down = 2'b01;
        repeat (300 * PER) begin
            step();
            if (pos1[9:0] > 10'd469) chk("pos0_overshoot", 32'(pos1[9:0]), 32'd469);
        end
        chk("clamp_bottom", 32'(pos1[9:0]), 32'd469);
        btn_down = 2'b00; btn_up = 2'b01;
        repeat (300 * PER) step();
        chk("clamp_top", 32'(pos1[9:0]), 32'd10);

        // T3: conflict holds, freeze holds while tick continues
        saved0 = int'(pos1[9:0]);
        saved1 = int'(pos1[19:10]);
        btn_up = 2'b11; btn_down = 2'b11;
        repeat (5 * PER) step();
        chk("conflict_hold0", 32'(pos1[9:0]), 32'(saved0));
        chk("conflict_hold1", 32'(pos1[19:10]), 32'(saved1));
        btn_up = 2'b00; freeze = 1'b1;
        repeat (4) step();
        ticks_seen = 0;
        repeat (5 * PER) begin
            if (tick1 === 1'b1) ticks_seen++;
            step();
        end
        chk("freeze_ticks", 32'(ticks_seen), 32'd5);
        chk("freeze_hold0", 32'(pos1[9:0]), 32'(saved0));
        chk("freeze_hold1", 32'(pos1[19:10]), 32'(saved1));
        freeze = 1'b0;

        // Randomized buttons, freeze and pixel coordinates
        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) begin
                btn_up   = 2'($urandom);
                btn_down = 2'($urandom);
                freeze   = ($urandom_range(0, 7) == 0);
            end
            cx = 10'($urandom_range(200, 639));
            if ($urandom_range(0, 1) == 1)
                cy = 10'(mpos[$urandom_range(0, 1)] + $urandom_range(0, 24) - 12);
            else
                cy = 10'($urandom_range(0, 479));
            disp = ($urandom_range(0, 7) != 0);
            step();
        end

        // T6: async reset between edges while a paddle pixel is lit
        btn_up = 2'b00; btn_down = 2'b00; freeze = 1'b0;
        cx = 10'd230; cy = 10'(mpos[0]); disp = 1'b1;
        step();
        chk("pre_reset_lit", 32'({r1, g1, b1}), 32'(3'b100));
        #3 reset = 1'b1;
        #1;
        chk("async_rgb", 32'({r1, g1, b1}), 32'(3'b000));
        chk("async_rgb_overlap", 32'({r2, g2, b2}), 32'(3'b000));
        chk("async_pos", 32'(pos1), 32'({10'd240, 10'd240}));
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (2 * PER) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
